clk_edge_monitor: RTL and testbench

CLK_EDGE_MONITOR -- requirements
Module: clk_edge_monitor

---
 rtl/clk_mon_pkg.sv | 31 +++
 rtl/sync_chain.sv | 42 ++++
 rtl/clk_edge_monitor.sv | 174 +++++++++++++++++
 tb/tb_clk_edge_monitor.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_mon_pkg
// Purpose  : Shared definitions for the clk_edge_monitor block: monitor
//            state encoding, default period-counter width and a small
//            state-classification helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clk_mon_pkg;

  // Default width of the period counter.
  localparam int CLK_MON_CNT_W = 26;

  // Monitor states; encoding is fixed so software/debug views stay stable.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKED  = 2'd2,
    STALLED = 2'd3
  } mon_state_e;

  // True in the states where a reference rising edge is known, i.e. where a
  // rise closes a period measurement and the stall timeout is active.
  function automatic logic is_tracking(input mon_state_e st);
    return (st == ARMED) || (st == LOCKED);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Purpose  : Multi-flop synchronizer bringing an asynchronous single-bit
//            signal into the clk domain.
// Params   : STAGES - number of flops in the chain (2..4)
// Ports    : clk   - sampling clock
//            reset - asynchronous active-low reset, clears every stage
//            d     - asynchronous input
//            q     - synchronized output (last stage)
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at bit 0; bit STAGES-1 is the settled sample.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clk_edge_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clk_edge_monitor
// Purpose  : Watches a slow clock (clk_in) that is asynchronous to clk,
//            flags each rising edge, measures the rise-to-rise period in clk
//            cycles and reports lock / stall status.
// Params   : SYNC_STAGES - synchronizer depth (2..4)
//            CNT_W       - period counter width
//            TIMEOUT     - clk cycles without a rise before stall
// Ports    : clk          - system clock, all logic on its rising edge
//            reset        - asynchronous active-low reset
//            clk_in       - monitored slow clock (asynchronous)
//            rise_tick    - one-cycle pulse per detected clk_in rise
//            period       - last measured period (clk cycles, saturating)
//            period_valid - one-cycle pulse when period updates
//            locked       - high while in LOCKED
//            stalled      - high while in STALLED
//            fall_tick    - (CLK_MON_FALL_EN) pulse per detected fall
//            high_time    - (CLK_MON_FALL_EN) high phase length of clk_in
// Macro    : CLK_MON_FALL_EN - adds falling-edge detection and high_time
// Revision : 1.0 - initial release
// ============================================================================
module clk_edge_monitor
  import clk_mon_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = CLK_MON_CNT_W,
  parameter int unsigned TIMEOUT     = (2**CNT_W) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             rise_tick,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             stalled
`ifdef CLK_MON_FALL_EN
  ,
  output logic             fall_tick,
  output logic [CNT_W-1:0] high_time
`endif
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  // --------------------------------------------------------------------------
  // Synchronizer and edge detection
  // --------------------------------------------------------------------------
  logic w_sync;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync_chain (
    .clk   (clk),
    .reset (reset),
    .d     (clk_in),
    .q     (w_sync)
  );

  logic             s_dly_q,        s_dly_d;
  logic             rise_tick_q,    rise_tick_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [CNT_W-1:0] period_q,       period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q,       locked_d;
  logic             stalled_q,      stalled_d;
  mon_state_e       state_q,        state_d;

  logic             w_rise;
  logic             w_tracking;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_rise     = w_sync & ~s_dly_q;
  assign w_tracking = is_tracking(state_q);
  // Saturating increment; also equals "cnt+1 (saturated)" used as the
  // measured period, since a rise ends the cycle in which cnt was counted.
  assign w_cnt_inc  = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef CLK_MON_FALL_EN
  logic             w_fall;
  logic             fall_tick_q, fall_tick_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;

  assign w_fall = ~w_sync & s_dly_q;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    s_dly_d        = w_sync;
    rise_tick_d    = w_rise;
    cnt_d          = w_rise ? '0 : w_cnt_inc;
    period_d       = period_q;
    period_valid_d = 1'b0;
    state_d        = state_q;

    if (w_rise) begin
      if (w_tracking) begin
        period_d       = w_cnt_inc;
        period_valid_d = 1'b1;
        state_d        = LOCKED;
      end else begin
        // First rise after reset or stall only establishes a reference.
        state_d = ARMED;
      end
    end else if (w_tracking && (w_cnt_inc == c_timeout)) begin
      // Compare the incremented value so stalled rises exactly TIMEOUT
      // cycles after the rise_tick that cleared the counter.
      state_d = STALLED;
    end

    locked_d  = (state_d == LOCKED);
    stalled_d = (state_d == STALLED);
  end

`ifdef CLK_MON_FALL_EN
  always_comb begin
    fall_tick_d = w_fall;
    high_time_d = high_time_q;
    if (w_fall && w_tracking) begin
      high_time_d = w_cnt_inc;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_dly_q        <= 1'b0;
      rise_tick_q    <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stalled_q      <= 1'b0;
      state_q        <= IDLE;
`ifdef CLK_MON_FALL_EN
      fall_tick_q    <= 1'b0;
      high_time_q    <= '0;
`endif
    end else begin
      s_dly_q        <= s_dly_d;
      rise_tick_q    <= rise_tick_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      stalled_q      <= stalled_d;
      state_q        <= state_d;
`ifdef CLK_MON_FALL_EN
      fall_tick_q    <= fall_tick_d;
      high_time_q    <= high_time_d;
`endif
    end
  end

  assign rise_tick    = rise_tick_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stalled      = stalled_q;
`ifdef CLK_MON_FALL_EN
  assign fall_tick    = fall_tick_q;
  assign high_time    = high_time_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_edge_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_clk_edge_monitor
// Purpose  : Self-checking bench for clk_edge_monitor. Three instances with
//            different synchronizer depth / counter width / timeout share one
//            clk_in stream; an elapsed-time reference model predicts every
//            output of every instance each cycle.
//            Instance A: SYNC_STAGES=2, CNT_W=26, TIMEOUT=default
//            Instance B: SYNC_STAGES=3, CNT_W=8,  TIMEOUT=16
//            Instance C: SYNC_STAGES=4, CNT_W=4,  TIMEOUT=15
// Macro    : CLK_MON_FALL_EN - also checks fall_tick / high_time
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_edge_monitor;

  localparam int          SS_A = 2;
  localparam int          CW_A = 26;
  localparam int unsigned TO_A = (2**26) - 1;
  localparam int          SS_B = 3;
  localparam int          CW_B = 8;
  localparam int unsigned TO_B = 16;
  localparam int          SS_C = 4;
  localparam int          CW_C = 4;
  localparam int unsigned TO_C = 15;

  logic clk = 1'b0;
  logic reset;
  logic clk_in;

  always #5 clk = ~clk;

  logic            rt_a, pv_a, lk_a, st_a;
  logic [CW_A-1:0] per_a;
  logic            rt_b, pv_b, lk_b, st_b;
  logic [CW_B-1:0] per_b;
  logic            rt_c, pv_c, lk_c, st_c;
  logic [CW_C-1:0] per_c;
`ifdef CLK_MON_FALL_EN
  logic            ft_a, ft_b, ft_c;
  logic [CW_A-1:0] ht_a;
  logic [CW_B-1:0] ht_b;
  logic [CW_C-1:0] ht_c;
`endif

  clk_edge_monitor #(.SYNC_STAGES(SS_A), .CNT_W(CW_A), .TIMEOUT(TO_A)) dut_a (
    .clk(clk), .reset(reset), .clk_in(clk_in), .rise_tick(rt_a), .period(per_a),
    .period_valid(pv_a), .locked(lk_a), .stalled(st_a)
`ifdef CLK_MON_FALL_EN
    , .fall_tick(ft_a), .high_time(ht_a)
`endif
  );

  clk_edge_monitor #(.SYNC_STAGES(SS_B), .CNT_W(CW_B), .TIMEOUT(TO_B)) dut_b (
    .clk(clk), .reset(reset), .clk_in(clk_in), .rise_tick(rt_b), .period(per_b),
    .period_valid(pv_b), .locked(lk_b), .stalled(st_b)
`ifdef CLK_MON_FALL_EN
    , .fall_tick(ft_b), .high_time(ht_b)
`endif
  );

  clk_edge_monitor #(.SYNC_STAGES(SS_C), .CNT_W(CW_C), .TIMEOUT(TO_C)) dut_c (
    .clk(clk), .reset(reset), .clk_in(clk_in), .rise_tick(rt_c), .period(per_c),
    .period_valid(pv_c), .locked(lk_c), .stalled(st_c)
`ifdef CLK_MON_FALL_EN
    , .fall_tick(ft_c), .high_time(ht_c)
`endif
  );

  int checks = 0;
  int errors = 0;

  // --------------------------------------------------------------------------
  // Reference model: sampled clk_in history plus, per instance, the cycle of
  // the last rise and a coarse mode (0 idle, 1 armed, 2 locked, 3 stalled).
  // --------------------------------------------------------------------------
  int unsigned m_ss  [3] = '{SS_A, SS_B, SS_C};
  int unsigned m_max [3] = '{(2**CW_A) - 1, (2**CW_B) - 1, (2**CW_C) - 1};
  int unsigned m_to  [3] = '{TO_A, TO_B, TO_C};
  int unsigned m_last[3];
  int unsigned m_mode[3];
  int unsigned m_per [3];
  int unsigned m_ht  [3];
  bit          m_rt  [3];
  bit          m_pv  [3];
  bit          m_ft  [3];
  bit          hist  [0:7];
  int unsigned cyc;

  function automatic int unsigned sat(input int unsigned v, input int unsigned m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) hist[k] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_last[i] = cyc;
      m_mode[i] = 0;
      m_per[i]  = 0;
      m_ht[i]   = 0;
      m_rt[i]   = 1'b0;
      m_pv[i]   = 1'b0;
      m_ft[i]   = 1'b0;
    end
  endtask

  task automatic model_edge();
    int unsigned el;
    bit r, f, trk;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = clk_in;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      // An edge becomes visible SYNC_STAGES samples after it was captured.
      r   = hist[m_ss[i]] & ~hist[m_ss[i]+1];
      f   = ~hist[m_ss[i]] & hist[m_ss[i]+1];
      el  = sat(cyc - m_last[i], m_max[i]);
      trk = (m_mode[i] == 1) || (m_mode[i] == 2);
      m_rt[i] = r;
      m_ft[i] = f;
      m_pv[i] = 1'b0;
      if (f && trk) m_ht[i] = el;
      if (r) begin
        if (trk) begin
          m_per[i]  = el;
          m_pv[i]   = 1'b1;
          m_mode[i] = 2;
        end else begin
          m_mode[i] = 1;
        end
        m_last[i] = cyc;
      end else if (trk && (el == m_to[i])) begin
        m_mode[i] = 3;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Comparison helpers
  // --------------------------------------------------------------------------
  task automatic cmp(input string tag, input int idx, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] o_rt[3], o_pv[3], o_per[3], o_lk[3], o_st[3];
    o_rt[0] = {31'b0, rt_a}; o_pv[0] = {31'b0, pv_a}; o_per[0] = 32'(per_a);
    o_lk[0] = {31'b0, lk_a}; o_st[0] = {31'b0, st_a};
    o_rt[1] = {31'b0, rt_b}; o_pv[1] = {31'b0, pv_b}; o_per[1] = 32'(per_b);
    o_lk[1] = {31'b0, lk_b}; o_st[1] = {31'b0, st_b};
    o_rt[2] = {31'b0, rt_c}; o_pv[2] = {31'b0, pv_c}; o_per[2] = 32'(per_c);
    o_lk[2] = {31'b0, lk_c}; o_st[2] = {31'b0, st_c};
    for (int i = 0; i < 3; i++) begin
      cmp("rise_tick",    i, o_rt[i],  32'(m_rt[i]));
      cmp("period_valid", i, o_pv[i],  32'(m_pv[i]));
      cmp("period",       i, o_per[i], m_per[i]);
      cmp("locked",       i, o_lk[i],  32'(m_mode[i] == 2));
      cmp("stalled",      i, o_st[i],  32'(m_mode[i] == 3));
    end
`ifdef CLK_MON_FALL_EN
    cmp("fall_tick", 0, {31'b0, ft_a}, 32'(m_ft[0]));
    cmp("fall_tick", 1, {31'b0, ft_b}, 32'(m_ft[1]));
    cmp("fall_tick", 2, {31'b0, ft_c}, 32'(m_ft[2]));
    cmp("high_time", 0, 32'(ht_a), m_ht[0]);
    cmp("high_time", 1, 32'(ht_b), m_ht[1]);
    cmp("high_time", 2, 32'(ht_c), m_ht[2]);
`endif
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_rise_tick"}, 0, {31'b0, rt_a}, 0);
    cmp({tag, "_period"},    0, 32'(per_a),    0);
    cmp({tag, "_pv"},        0, {31'b0, pv_a}, 0);
    cmp({tag, "_locked"},    0, {31'b0, lk_a}, 0);
    cmp({tag, "_stalled"},   0, {31'b0, st_a}, 0);
    cmp({tag, "_period"},    1, 32'(per_b),    0);
    cmp({tag, "_locked"},    1, {31'b0, lk_b}, 0);
    cmp({tag, "_stalled"},   1, {31'b0, st_b}, 0);
    cmp({tag, "_period"},    2, 32'(per_c),    0);
    cmp({tag, "_stalled"},   2, {31'b0, st_c}, 0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers; each call starts and ends 1 ns after a rising clk edge.
  // --------------------------------------------------------------------------
  task automatic step(input logic v, input bit glitch = 1'b0);
    if (glitch) begin
      // Pulse high and back low between clk edges: never sampled.
      clk_in = 1'b1;
      #2;
      clk_in = 1'b0;
    end else begin
      clk_in = v;
    end
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check_all();
  endtask

  task automatic run_wave(input int hi, input int lo, input int n);
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < hi; k++) step(1'b1);
      for (int k = 0; k < lo; k++) step(1'b0);
    end
  endtask

  task automatic async_reset(input int hold);
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    reset = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int lat;
    int hi, lo;
    cyc    = 0;
    reset  = 1'b0;
    clk_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    check_all();
    reset = 1'b1;

    // First rise: latency counted in clk edges from the capturing edge.
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      if ((rt_a === 1'b1) && (lat == 0)) lat = k;
    end
    cmp("first_rise_latency", 0, 32'(lat), 32'(SS_A + 1));
    for (int k = 0; k < 4; k++) step(1'b0);
    run_wave(4, 4, 4);
    cmp("period_8", 0, 32'(per_a), 8);
    cmp("locked_8", 0, {31'b0, lk_a}, 1);

    // Period change to 20: A reports 20, B and C time out between rises.
    run_wave(10, 10, 3);
    cmp("period_20", 0, 32'(per_a), 20);
    cmp("period_hold_b", 1, 32'(per_b), 8);

    // clk_in held low after lock.
    run_wave(4, 4, 3);
    for (int k = 0; k < 30; k++) step(1'b0);
    cmp("stall_b", 1, {31'b0, st_b}, 1);
    cmp("stall_c", 2, {31'b0, st_c}, 1);
    cmp("no_stall_a", 0, {31'b0, st_a}, 0);

    // Relock, then asynchronous reset while clk_in is high.
    run_wave(4, 4, 3);
    step(1'b1);
    step(1'b1);
    async_reset(2);
    step(1'b1);
    step(1'b1);
    for (int k = 0; k < 4; k++) step(1'b0);
    run_wave(4, 4, 2);

    // Period equal to C's timeout: the rise wins the tie.
    run_wave(7, 8, 4);
    cmp("period_15_c", 2, 32'(per_c), 15);
    cmp("locked_15_c", 2, {31'b0, lk_c}, 1);

    // Period 40 on the 4-bit instance: stalls before saturating.
    run_wave(20, 20, 3);
    cmp("stall_40_c", 2, {31'b0, st_c}, 1);
    cmp("period_held_c", 2, 32'(per_c), 15);
    cmp("period_40_a", 0, 32'(per_a), 40);

    // Sub-cycle glitches must not register as edges.
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1);

    // Randomized waveform, with occasional long gaps to provoke stalls.
    for (int p = 0; p < 25; p++) begin
      hi = int'($urandom_range(1, 12));
      lo = int'($urandom_range(1, 14));
      if ($urandom_range(0, 4) == 0) lo = lo + 20;
      for (int k = 0; k < hi; k++) step(1'b1);
      for (int k = 0; k < lo; k++) step(1'b0, ($urandom_range(0, 7) == 0));
    end

    // 25% duty cycle, period 16.
    run_wave(4, 12, 4);
    cmp("period_16", 0, 32'(per_a), 16);
`ifdef CLK_MON_FALL_EN
    cmp("high_time_4", 0, 32'(ht_a), 4);
    cmp("high_time_4", 2, 32'(ht_c), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
